// File: rtl/cpu_run_control.sv
// cpu_run_control: run/pause/step/halt sequencer with debug counters.
// Ports: clk, reset (sync, active-high), stop, start, step, instr_done,
//   halt_op -> run, cpu_en, halted, fault, state[2:0], cycle_count,
//   instr_count. Optional watchdog: define CPU_RUN_CONTROL_WATCHDOG_EN.
module cpu_run_control #(
  parameter bit AUTO_START = 1'b1,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic             start,
  input  logic             step,
  input  logic             instr_done,
  input  logic             halt_op,
  output logic             run,
  output logic             cpu_en,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_PAUSE  = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [2:0] S_INIT = AUTO_START ? S_RUN : S_PAUSE;

  logic [2:0] nxt;
  logic       start_q;
  logic       step_q;
  logic       start_edge;
  logic       step_edge;
  logic       done_en;
  logic       wdog_trip;

  assign start_edge = start & ~start_q;
  assign step_edge  = step & ~step_q;

  assign run    = (state == S_RUN) | (state == S_DRAIN) |
                  (state == S_STEP);
  assign cpu_en = run;
  assign halted = (state == S_HALTED);

  // A completion pulse only matters while the sequencer is enabled.
  assign done_en = instr_done & cpu_en;

`ifdef CPU_RUN_CONTROL_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_LIMIT + 1);

  logic [WW-1:0] wdog_cnt;
  logic          fault_q;

  // Trip on the enabled cycle that would bring the count to the limit.
  assign wdog_trip = cpu_en & ~instr_done &
                     (wdog_cnt == WW'(WDOG_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (!cpu_en || instr_done)
        wdog_cnt <= '0;
      else if (!wdog_trip)
        wdog_cnt <= wdog_cnt + WW'(1);
      if (wdog_trip && !halt_op)
        fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_LIMIT > 0);
  assign wdog_trip   = 1'b0;
  assign fault       = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_RUN: begin
        if (halt_op)   nxt = S_HALTED;
        else if (stop) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (halt_op)         nxt = S_HALTED;
        else if (instr_done) nxt = S_PAUSE;
      end
      S_STEP: begin
        if (halt_op)         nxt = S_HALTED;
        else if (instr_done) nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (step_edge)                nxt = S_STEP;
        else if (start_edge && !stop) nxt = S_RUN;
      end
      S_HALTED: nxt = S_HALTED;
      default:  nxt = S_INIT;
    endcase
    if (wdog_trip)
      nxt = S_HALTED;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INIT;
      start_q     <= 1'b1;
      step_q      <= 1'b1;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      state   <= nxt;
      start_q <= start;
      step_q  <= step;
      if (cpu_en && cycle_count != '1)
        cycle_count <= cycle_count + CNT_W'(1);
      if (done_en && instr_count != '1)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_control.sv
// tb_cpu_run_control: table-driven bench for cpu_run_control.
// Rows of {inputs, expected state/counters} go through a scoreboard queue.
module tb_cpu_run_control;

  localparam int CW = 5;
  localparam int WL = 8;

  localparam logic [2:0] P = 3'd0;
  localparam logic [2:0] R = 3'd1;
  localparam logic [2:0] D = 3'd2;
  localparam logic [2:0] S = 3'd3;
  localparam logic [2:0] H = 3'd4;

  logic          clk = 1'b0;
  logic          reset, stop, start, step, instr_done, halt_op;
  logic          run, cpu_en, halted, fault;
  logic [2:0]    state;
  logic [CW-1:0] cycle_count, instr_count;

  typedef struct {
    string      name;
    logic       rst, stp, sta, ste, dn, hl;
    logic [2:0] st;
    int         c, i;
    logic       f;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  cpu_run_control #(
    .AUTO_START(1'b1),
    .CNT_W(CW),
    .WDOG_LIMIT(WL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stop(stop),
    .start(start),
    .step(step),
    .instr_done(instr_done),
    .halt_op(halt_op),
    .run(run),
    .cpu_en(cpu_en),
    .halted(halted),
    .fault(fault),
    .state(state),
    .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic rs, logic sp, logic sa,
                              logic se, logic d, logic h, logic [2:0] st,
                              int c, int i, logic f = 1'b0);
    vec_t v;
    v.name = n; v.rst = rs; v.stp = sp; v.sta = sa;
    v.ste = se; v.dn = d; v.hl = h;
    v.st = st; v.c = c; v.i = i; v.f = f;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    logic er, ee, eh;
    reset = v.rst; stop = v.stp; start = v.sta;
    step = v.ste; instr_done = v.dn; halt_op = v.hl;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    er = (e.st == R) || (e.st == D) || (e.st == S);
    ee = er;
    eh = (e.st == H);
    checks++;
    if (state !== e.st || run !== er || cpu_en !== ee ||
        halted !== eh || fault !== e.f ||
        cycle_count !== CW'(e.c) || instr_count !== CW'(e.i)) begin
      errors++;
      $display("FAIL %s: got st=%0d run=%b en=%b hlt=%b flt=%b cyc=%0d ins=%0d want st=%0d run=%b en=%b hlt=%b flt=%b cyc=%0d ins=%0d",
               e.name, state, run, cpu_en, halted, fault,
               cycle_count, instr_count,
               e.st, er, ee, eh, e.f, e.c, e.i);
    end
  endtask

  initial begin
    reset = 1'b1; stop = 1'b0; start = 1'b0;
    step = 1'b0; instr_done = 1'b0; halt_op = 1'b0;

    //                 name      rst stp sta ste dn hl  st c  i
    vecs.push_back(mk("rst0",    1, 0, 0, 0, 0, 0, R,  0, 0));
    vecs.push_back(mk("rst1",    1, 0, 0, 0, 0, 0, R,  0, 0));
    vecs.push_back(mk("run1",    0, 0, 0, 0, 0, 0, R,  1, 0));
    vecs.push_back(mk("run2",    0, 0, 0, 0, 0, 0, R,  2, 0));
    vecs.push_back(mk("run3",    0, 0, 0, 0, 0, 0, R,  3, 0));
    vecs.push_back(mk("run4",    0, 0, 0, 0, 1, 0, R,  4, 1));
    vecs.push_back(mk("run5",    0, 0, 0, 0, 0, 0, R,  5, 1));
    vecs.push_back(mk("run6",    0, 0, 0, 0, 0, 0, R,  6, 1));
    vecs.push_back(mk("run7",    0, 0, 0, 0, 0, 0, R,  7, 1));
    vecs.push_back(mk("run8",    0, 0, 0, 0, 1, 0, R,  8, 2));
    vecs.push_back(mk("run9",    0, 0, 0, 0, 0, 0, R,  9, 2));
    vecs.push_back(mk("run10",   0, 0, 0, 0, 0, 0, R, 10, 2));
    vecs.push_back(mk("run11",   0, 0, 0, 0, 0, 0, R, 11, 2));
    vecs.push_back(mk("run12",   0, 0, 0, 0, 1, 0, R, 12, 3));
    vecs.push_back(mk("stop",    0, 1, 0, 0, 0, 0, D, 13, 3));
    vecs.push_back(mk("drain_lo",0, 0, 0, 0, 0, 0, D, 14, 3));
    vecs.push_back(mk("drain_dn",0, 0, 0, 0, 1, 0, P, 15, 4));
    vecs.push_back(mk("pz_done", 0, 0, 0, 0, 1, 0, P, 15, 4));
    vecs.push_back(mk("pz_idle", 0, 0, 0, 0, 0, 0, P, 15, 4));
    vecs.push_back(mk("step_e",  0, 0, 0, 1, 0, 0, S, 15, 4));
    vecs.push_back(mk("step_hd", 0, 0, 0, 1, 0, 0, S, 16, 4));
    vecs.push_back(mk("step_lo", 0, 0, 0, 0, 0, 0, S, 17, 4));
    vecs.push_back(mk("step_dn", 0, 0, 0, 1, 1, 0, P, 18, 5));
    vecs.push_back(mk("step_hi", 0, 0, 0, 1, 0, 0, P, 18, 5));
    vecs.push_back(mk("step_rl", 0, 0, 0, 0, 0, 0, P, 18, 5));
    vecs.push_back(mk("sta_stp", 0, 1, 1, 0, 0, 0, P, 18, 5));
    vecs.push_back(mk("sta_hld", 0, 0, 1, 0, 0, 0, P, 18, 5));
    vecs.push_back(mk("sta_rl",  0, 0, 0, 0, 0, 0, P, 18, 5));
    vecs.push_back(mk("sta_e",   0, 0, 1, 0, 0, 0, R, 18, 5));
    vecs.push_back(mk("run_a",   0, 0, 0, 0, 0, 0, R, 19, 5));
    vecs.push_back(mk("halt_dn", 0, 0, 0, 0, 1, 1, H, 20, 6));
    vecs.push_back(mk("h_start", 0, 0, 1, 0, 0, 0, H, 20, 6));
    vecs.push_back(mk("h_step",  0, 0, 0, 1, 0, 0, H, 20, 6));
    vecs.push_back(mk("h_stopdn",0, 1, 0, 0, 1, 0, H, 20, 6));
    vecs.push_back(mk("h_reset", 1, 0, 0, 0, 0, 0, R,  0, 0));
    vecs.push_back(mk("stop2",   0, 1, 0, 0, 0, 0, D,  1, 0));
    vecs.push_back(mk("drain_h", 0, 1, 0, 0, 0, 1, H,  2, 0));
    vecs.push_back(mk("h_rst2",  1, 0, 0, 0, 0, 0, R,  0, 0));

    foreach (vecs[k]) apply(vecs[k]);

    // Back-to-back completions: both counters saturate at all-ones.
    for (int n = 1; n <= 35; n++) begin
      int m;
      m = (n > 31) ? 31 : n;
      apply(mk($sformatf("sat%0d", n), 0, 0, 0, 0, 1, 0, R, m, m));
    end

    apply(mk("wd_rst", 1, 0, 0, 0, 0, 0, R, 0, 0));

    // No completions at all: watchdog trips, or the run just continues.
    for (int n = 1; n <= 40; n++) begin
`ifdef CPU_RUN_CONTROL_WATCHDOG_EN
      if (n < WL)
        apply(mk($sformatf("wd%0d", n), 0, 0, 0, 0, 0, 0, R, n, 0));
      else
        apply(mk($sformatf("wd%0d", n), 0, 0, 0, 0, 0, 0, H, WL, 0,
                 1'b1));
`else
      apply(mk($sformatf("wd%0d", n), 0, 0, 0, 0, 0, 0, R,
               (n > 31) ? 31 : n, 0));
`endif
    end

    apply(mk("end_rst", 1, 0, 0, 0, 0, 0, R, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
